// File: rtl/intr_ctrl.sv
// Machine-mode interrupt controller: synchronises timer/external lines,
// prioritises eligible requests and runs the req/ack/mret handshake.
module intr_ctrl #(
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_TRIG   = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          t_intr_i,
    input  logic          e_intr_i,
    input  logic          mstatus_mie_i,
    input  logic          mie_mtie_i,
    input  logic          mie_meie_i,
    input  logic          intr_ack_i,
    input  logic          mret_i,
    output logic          intr_req_o,
    output logic [DW-1:0] intr_cause_o,
    output logic [DW-1:0] mip_o,
    output logic          in_service_o
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    localparam logic [DW-1:0] CAUSE_E = {1'b1, {(DW-5){1'b0}}, 4'hB};
    localparam logic [DW-1:0] CAUSE_T = {1'b1, {(DW-5){1'b0}}, 4'h7};

    logic [SYNC_STAGES-1:0] sync_t;
    logic [SYNC_STAGES-1:0] sync_e;
    logic                   s_t;
    logic                   s_e;
    logic                   pend_t;
    logic                   pend_e;
    logic                   elig_t;
    logic                   elig_e;
    logic                   elig_src;
    state_t                 state_q;
    state_t                 state_d;
    logic                   src_q;
    logic                   src_d;
    logic [DW-1:0]          cause_q;
    logic [DW-1:0]          cause_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_t <= '0;
            sync_e <= '0;
        end else begin
            sync_t[0] <= t_intr_i;
            sync_e[0] <= e_intr_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_t[i] <= sync_t[i-1];
                sync_e[i] <= sync_e[i-1];
            end
        end
    end

    assign s_t = sync_t[SYNC_STAGES-1];
    assign s_e = sync_e[SYNC_STAGES-1];

    if (EDGE_TRIG) begin : g_edge
        logic prev_t;
        logic prev_e;
        logic take;

        // src_q: 1 = external, 0 = timer; a new edge beats a same-cycle clear
        assign take = (state_q == REQ) && intr_ack_i;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                prev_t <= 1'b0;
                prev_e <= 1'b0;
                pend_t <= 1'b0;
                pend_e <= 1'b0;
            end else begin
                prev_t <= s_t;
                prev_e <= s_e;
                pend_t <= (s_t & ~prev_t) | (pend_t & ~(take & ~src_q));
                pend_e <= (s_e & ~prev_e) | (pend_e & ~(take & src_q));
            end
        end
    end else begin : g_level
        assign pend_t = s_t;
        assign pend_e = s_e;
    end

    always_comb begin
        mip_o     = '0;
        mip_o[11] = pend_e;
        mip_o[7]  = pend_t;
    end

    assign elig_e   = pend_e & mie_meie_i & mstatus_mie_i;
    assign elig_t   = pend_t & mie_mtie_i & mstatus_mie_i;
    assign elig_src = src_q ? elig_e : elig_t;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        cause_d = cause_q;
        unique case (state_q)
            IDLE: begin
                if (elig_e) begin
                    state_d = REQ;
                    src_d   = 1'b1;
                    cause_d = CAUSE_E;
                end else if (elig_t) begin
                    state_d = REQ;
                    src_d   = 1'b0;
                    cause_d = CAUSE_T;
                end
            end
            REQ: begin
                if (intr_ack_i) begin
                    state_d = SERVICE;
                end else if (!elig_src) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (mret_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            src_q   <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            cause_q <= cause_d;
        end
    end

    assign intr_req_o   = (state_q == REQ);
    assign in_service_o = (state_q == SERVICE);
    assign intr_cause_o = cause_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: edge-mode instance plus a level-mode
// instance sharing clock, reset and enables.
module tb_intr_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        t_intr_i, e_intr_i;
    logic        mstatus_mie_i, mie_mtie_i, mie_meie_i;
    logic        intr_ack_i, mret_i;
    logic        intr_req_o, in_service_o;
    logic [31:0] intr_cause_o, mip_o;

    logic        l_e, l_ack, l_mret;
    logic        l_req, l_svc;
    logic [31:0] l_cause, l_mip;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] C_T = 32'h8000_0007;
    localparam logic [31:0] C_E = 32'h8000_000B;

    always #5 clk_i = ~clk_i;

    intr_ctrl #(.DW(32), .SYNC_STAGES(2), .EDGE_TRIG(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .t_intr_i(t_intr_i), .e_intr_i(e_intr_i),
        .mstatus_mie_i(mstatus_mie_i), .mie_mtie_i(mie_mtie_i),
        .mie_meie_i(mie_meie_i), .intr_ack_i(intr_ack_i),
        .mret_i(mret_i), .intr_req_o(intr_req_o),
        .intr_cause_o(intr_cause_o), .mip_o(mip_o),
        .in_service_o(in_service_o)
    );

    intr_ctrl #(.DW(32), .SYNC_STAGES(2), .EDGE_TRIG(1'b0)) dut_lvl (
        .clk_i(clk_i), .rst_i(rst_i),
        .t_intr_i(1'b0), .e_intr_i(l_e),
        .mstatus_mie_i(mstatus_mie_i), .mie_mtie_i(mie_mtie_i),
        .mie_meie_i(mie_meie_i), .intr_ack_i(l_ack),
        .mret_i(l_mret), .intr_req_o(l_req),
        .intr_cause_o(l_cause), .mip_o(l_mip),
        .in_service_o(l_svc)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_ack;
        intr_ack_i = 1'b1;
        tick();
        intr_ack_i = 1'b0;
    endtask

    task automatic do_mret;
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t_intr_i = i[0];
            e_intr_i = ~i[0];
            intr_ack_i = i[1];
            mret_i = i[0];
            tick();
        end
        checks++;
        if (intr_req_o !== 1'b0 || in_service_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_req_svc got=%b%b exp=00", intr_req_o, in_service_o);
        end
        checks++;
        if (intr_cause_o !== 32'h0 || mip_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_cause_mip got=%h/%h exp=0/0", intr_cause_o, mip_o);
        end
        t_intr_i = 0; e_intr_i = 0; intr_ack_i = 0; mret_i = 0;
        rst_i = 1'b1;
        tick(2);
    endtask

    task automatic test_latency;
        mstatus_mie_i = 1; mie_mtie_i = 1; mie_meie_i = 1;
        t_intr_i = 1'b1;
        tick(2);
        t_intr_i = 1'b0;
        checks++;
        if (intr_req_o !== 1'b0) begin
            errors++;
            $display("FAIL lat_k1 got=%b exp=0", intr_req_o);
        end
        tick();
        checks++;
        if (intr_req_o !== 1'b0 || mip_o !== 32'h80) begin
            errors++;
            $display("FAIL lat_k2 got=%b/%h exp=0/80", intr_req_o, mip_o);
        end
        tick();
        checks++;
        if (intr_req_o !== 1'b1 || intr_cause_o !== C_T) begin
            errors++;
            $display("FAIL lat_k3 got=%b/%h exp=1/%h", intr_req_o, intr_cause_o, C_T);
        end
    endtask

    task automatic test_handshake;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (intr_req_o !== 1'b1 || intr_cause_o !== C_T) begin
                errors++;
                $display("FAIL hs_hold%0d got=%b/%h exp=1/%h", i, intr_req_o, intr_cause_o, C_T);
            end
        end
        do_ack();
        checks++;
        if (intr_req_o !== 1'b0 || in_service_o !== 1'b1 || mip_o !== 32'h0) begin
            errors++;
            $display("FAIL hs_ack got=%b%b/%h exp=01/0", intr_req_o, in_service_o, mip_o);
        end
        do_mret();
        checks++;
        if (in_service_o !== 1'b0 || intr_req_o !== 1'b0) begin
            errors++;
            $display("FAIL hs_mret got=%b%b exp=00", intr_req_o, in_service_o);
        end
    endtask

    task automatic test_priority;
        t_intr_i = 1; e_intr_i = 1;
        tick(4);
        t_intr_i = 0; e_intr_i = 0;
        checks++;
        if (intr_req_o !== 1'b1 || intr_cause_o !== C_E || mip_o !== 32'h880) begin
            errors++;
            $display("FAIL pri_first got=%b/%h/%h exp=1/%h/880", intr_req_o, intr_cause_o, mip_o, C_E);
        end
        do_ack();
        checks++;
        if (in_service_o !== 1'b1 || mip_o !== 32'h80) begin
            errors++;
            $display("FAIL pri_ack got=%b/%h exp=1/80", in_service_o, mip_o);
        end
        do_mret();
        tick();
        checks++;
        if (intr_req_o !== 1'b1 || intr_cause_o !== C_T) begin
            errors++;
            $display("FAIL pri_second got=%b/%h exp=1/%h", intr_req_o, intr_cause_o, C_T);
        end
        do_ack();
        checks++;
        if (mip_o !== 32'h0) begin
            errors++;
            $display("FAIL pri_clear got=%h exp=0", mip_o);
        end
        do_mret();
    endtask

    task automatic test_gating;
        mstatus_mie_i = 1'b0;
        t_intr_i = 1'b1;
        tick(2);
        t_intr_i = 1'b0;
        tick(3);
        checks++;
        if (intr_req_o !== 1'b0 || mip_o !== 32'h80) begin
            errors++;
            $display("FAIL gate_off got=%b/%h exp=0/80", intr_req_o, mip_o);
        end
        mstatus_mie_i = 1'b1;
        tick();
        checks++;
        if (intr_req_o !== 1'b1 || intr_cause_o !== C_T) begin
            errors++;
            $display("FAIL gate_on got=%b/%h exp=1/%h", intr_req_o, intr_cause_o, C_T);
        end
        mie_mtie_i = 1'b0;
        tick();
        checks++;
        if (intr_req_o !== 1'b0 || mip_o !== 32'h80 || intr_cause_o !== C_T) begin
            errors++;
            $display("FAIL withdraw got=%b/%h/%h exp=0/80/%h", intr_req_o, mip_o, intr_cause_o, C_T);
        end
        mie_mtie_i = 1'b1;
        tick();
        checks++;
        if (intr_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rereq got=%b exp=1", intr_req_o);
        end
        do_ack();
        do_mret();
    endtask

    task automatic test_service_arrival;
        t_intr_i = 1'b1;
        tick(2);
        t_intr_i = 1'b0;
        tick(2);
        do_ack();
        e_intr_i = 1'b1;
        tick(4);
        e_intr_i = 1'b0;
        checks++;
        if (intr_req_o !== 1'b0 || in_service_o !== 1'b1 || mip_o !== 32'h800) begin
            errors++;
            $display("FAIL svc_arr got=%b%b/%h exp=01/800", intr_req_o, in_service_o, mip_o);
        end
        do_mret();
        checks++;
        if (intr_req_o !== 1'b0 || in_service_o !== 1'b0) begin
            errors++;
            $display("FAIL svc_mret got=%b%b exp=00", intr_req_o, in_service_o);
        end
        tick();
        checks++;
        if (intr_req_o !== 1'b1 || intr_cause_o !== C_E) begin
            errors++;
            $display("FAIL svc_next got=%b/%h exp=1/%h", intr_req_o, intr_cause_o, C_E);
        end
        do_ack();
        do_mret();
    endtask

    task automatic test_async_reset;
        t_intr_i = 1'b1;
        tick(2);
        t_intr_i = 1'b0;
        tick(2);
        checks++;
        if (intr_req_o !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre got=%b exp=1", intr_req_o);
        end
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (intr_req_o !== 1'b0 || intr_cause_o !== 32'h0 || mip_o !== 32'h0) begin
            errors++;
            $display("FAIL ar_now got=%b/%h/%h exp=0/0/0", intr_req_o, intr_cause_o, mip_o);
        end
        tick();
        rst_i = 1'b1;
        tick(2);
    endtask

    task automatic test_level;
        l_e = 1'b1;
        tick(3);
        checks++;
        if (l_req !== 1'b1 || l_cause !== C_E || l_mip !== 32'h800) begin
            errors++;
            $display("FAIL lvl_req got=%b/%h/%h exp=1/%h/800", l_req, l_cause, l_mip, C_E);
        end
        l_ack = 1'b1;
        tick();
        l_ack = 1'b0;
        checks++;
        if (l_svc !== 1'b1 || l_mip !== 32'h800) begin
            errors++;
            $display("FAIL lvl_ack got=%b/%h exp=1/800", l_svc, l_mip);
        end
        l_mret = 1'b1;
        tick();
        l_mret = 1'b0;
        tick();
        checks++;
        if (l_req !== 1'b1 || l_cause !== C_E) begin
            errors++;
            $display("FAIL lvl_rereq got=%b/%h exp=1/%h", l_req, l_cause, C_E);
        end
        l_e = 1'b0;
        tick();
        checks++;
        if (l_mip !== 32'h800) begin
            errors++;
            $display("FAIL lvl_hold got=%h exp=800", l_mip);
        end
        tick();
        checks++;
        if (l_mip !== 32'h0) begin
            errors++;
            $display("FAIL lvl_drop got=%h exp=0", l_mip);
        end
        tick();
        checks++;
        if (l_req !== 1'b0) begin
            errors++;
            $display("FAIL lvl_wd got=%b exp=0", l_req);
        end
    endtask

    initial begin
        rst_i = 0; t_intr_i = 0; e_intr_i = 0;
        mstatus_mie_i = 0; mie_mtie_i = 0; mie_meie_i = 0;
        intr_ack_i = 0; mret_i = 0;
        l_e = 0; l_ack = 0; l_mret = 0;
        test_reset();
        test_latency();
        test_handshake();
        test_priority();
        test_gating();
        test_service_arrival();
        test_async_reset();
        test_level();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Machine-mode interrupt controller that sits between the core's external interrupt pins and the pipeline/CSR unit. It synchronises and latches timer (t_intr) and external (e_intr) requests, gates them with the CSR enables, and presents at most one prioritised request with its mcause value. The request uses a req/ack handshake with the pipeline's trap logic. Its in-service state tracks the handler until mret.

Parameters:
DW, 32, data width of intr_cause_o and mip_o
SYNC_STAGES, 2, flop stages on each interrupt input (legal 1..4)
EDGE_TRIG, 1, 1 = rising-edge latched pending; 0 = level-sensitive pending

Ports:
clk_i  input  1  core clock
rst_i  input  1  asynchronous, active-low reset
t_intr_i  input  1  timer interrupt line, asynchronous to clk_i
e_intr_i  input  1  external interrupt line, asynchronous to clk_i
mstatus_mie_i  input  1  global machine interrupt enable (mstatus.MIE)
mie_mtie_i  input  1  timer interrupt enable (mie[7])
mie_meie_i  input  1  external interrupt enable (mie[11])
intr_ack_i  input  1  pipeline has taken the trap for the current request
mret_i  input  1  mret retired; handler finished
intr_req_o  output  1  interrupt request to pipeline
intr_cause_o  output  DW  mcause value for the current request
mip_o  output  DW  pending bits: [11]=MEIP, [7]=MTIP, all others 0
in_service_o  output  1  handler in progress

Behaviour:
- Reset (rst_i=0, asynchronous): sync flops, previous-sample flops and pending bits cleared. State=IDLE. intr_req_o=0, intr_cause_o=0, mip_o=0, in_service_o=0.
- Synchroniser: each input passes through SYNC_STAGES flops. s_t and s_e are the synchronised outputs.
- EDGE_TRIG=1: pending bit set on the clock where s_x=1 and the previous s_x=0. It is cleared only by ack of that source. If set and clear hit the same cycle, set wins.
- EDGE_TRIG=0: pending = s_x directly. Ack does not clear it; the source must deassert.
- mip_o[11]=pend_e, mip_o[7]=pend_t. These are raw and not gated by enables.
- Eligible: elig_e = pend_e & mie_meie_i & mstatus_mie_i; elig_t = pend_t & mie_mtie_i & mstatus_mie_i.
- Priority: external over timer.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if elig_e, go to REQ and latch cause 0x8000000B with src=E. Else if elig_t, go to REQ and latch cause 0x80000007 with src=T.
  - REQ: intr_req_o=1 and intr_cause_o holds the latched value, stable until ack.
    - If intr_ack_i=1: clear pending[src] (edge mode), go to SERVICE.
    - Else if elig[src]=0 (enable dropped or level fell): withdraw and go to IDLE. intr_req_o=0 next cycle and intr_cause_o is kept.
    - If ack and withdraw happen in the same cycle, ack wins.
    - A higher-priority source arriving while in REQ does not preempt the latched source.
  - SERVICE: in_service_o=1 and intr_req_o=0. New edges still set pending bits. On mret_i=1, go to IDLE.
  - No nesting. intr_ack_i outside REQ and mret_i outside SERVICE are ignored.
- intr_req_o, intr_cause_o and in_service_o are registered, decoded from the state/cause flops.
- Latency (SYNC_STAGES=2, EDGE_TRIG=1, enables high): input high before edge k → s_x high after edge k+1 → pending after k+2 → intr_req_o high after k+3.
- Minimum accepted pulse width is 1 clock after synchronisation. A pulse shorter than one clock period may be lost.
- Reset asserted mid-request or mid-service returns to IDLE immediately, without waiting for a clock.
- intr_cause_o upper bits beyond 32 are 0 when DW>32. Bit DW-1 always carries the interrupt flag.

Test Plan:
- Reset: drive rst_i=0 with inputs toggling → all outputs 0. Release, enables=1, pulse t_intr_i for 2 clocks → intr_req_o=1 exactly 3 edges after the first sampled-high edge, intr_cause_o=0x80000007, mip_o=0x80.
- Handshake: while in REQ, hold intr_ack_i=0 for 5 cycles → req/cause stable. Then ack=1 for 1 cycle → next cycle intr_req_o=0, in_service_o=1, mip_o[7]=0. mret_i=1 → in_service_o=0.
- Priority: t and e rise on the same edge → cause 0x8000000B first. After ack+mret, a second request follows with cause 0x80000007 and no new edge needed.
- Gating/withdraw: pend_t set with mstatus_mie_i=0 → no req, mip_o=0x80. Set MIE=1 → req. Drop mie_mtie_i while in REQ without ack → req falls next cycle and mip_o stays 0x80.
- Service-time arrival: e_intr_i edge during SERVICE → no req and mip_o[11]=1. On mret, req follows in the next cycle with cause 0x8000000B.
- Async reset mid-REQ and level mode (EDGE_TRIG=0): rst_i low between clock edges → intr_req_o=0 at once. In level mode, ack then mret with e_intr_i still high → re-request. Deassert e_intr_i → mip_o[11]=0 after 2 edges.
